// File: rtl/sbs_decoder_if.sv
// sbs_decoder_if: handshake bundle between a stochastic bitstream generator,
// the decoder and the consumer of the decoded value.
//   sbs       parallel stream, bit i = stream position i
//   in_valid  sbs holds a complete stream (generator done flag)
//   in_ready  decoder accepts a stream this cycle
//   value     count of ones in the accepted stream (0 unless out_valid)
//   out_valid value is final
//   out_ready consumer takes value this cycle
//   busy      decoder is counting or holding a result
// The master modport is the generator/consumer side; slave is the decoder.
interface sbs_decoder_if #(
  parameter int BSL   = 255,
  parameter int OUT_W = $clog2(BSL + 1)
);
  logic [BSL-1:0]   sbs;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] value;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output sbs, in_valid, out_ready,
    input  in_ready, value, out_valid, busy
  );

  modport slave (
    input  sbs, in_valid, out_ready,
    output in_ready, value, out_valid, busy
  );
endinterface

// File: rtl/sbs_decoder.sv
// sbs_decoder: converts a parallel unipolar stochastic bitstream into its
// binary estimate (number of ones), counting CHUNK bits per clock.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sbs_decoder_if.slave (sbs/in_valid/in_ready in,
//        value/out_valid/out_ready out, busy)
//
// state   | meaning
// S_IDLE  | ready for a stream; in_ready=1
// S_COUNT | popcounting the captured stream one chunk per edge
// S_DONE  | result presented until the consumer takes it
module sbs_decoder #(
  parameter int BSL   = 255,
  parameter int CHUNK = 8,
  parameter int OUT_W = $clog2(BSL + 1)
) (
  input logic         clk,
  input logic         rst,
  sbs_decoder_if.slave bus
);

  localparam int N     = (BSL + CHUNK - 1) / CHUNK;
  localparam int PAD_W = N * CHUNK;
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [BSL-1:0]   r_shadow;
  logic [OUT_W-1:0] r_acc;
  logic [K_W-1:0]   r_k;
  logic [PAD_W-1:0] w_padded;
  logic [CHUNK-1:0] w_chunk;
  logic [OUT_W-1:0] w_pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_COUNT;
      S_COUNT: if (r_k == K_LAST) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.value     = '0;
    case (r_state)
      S_IDLE:  bus.in_ready = 1'b1;
      S_COUNT: bus.busy = 1'b1;
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.value     = r_acc;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Shadow copy is taken only on the accept edge so later sbs changes are
  // invisible; it has no reset because it is don't-care until captured.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_IDLE && bus.in_valid) r_shadow <= bus.sbs;
  end

  // Zero-extend to a whole number of chunks so the final chunk's pad bits
  // contribute nothing.
  always_comb begin
    w_padded          = '0;
    w_padded[BSL-1:0] = r_shadow;
  end

  assign w_chunk = CHUNK'(w_padded >> (int'(r_k) * CHUNK));

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_pop = w_pop + OUT_W'(w_chunk[i]);
    end
  end

  // Accumulator and chunk index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_k   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        S_COUNT: begin
          r_acc <= r_acc + w_pop;
          r_k   <= r_k + K_W'(1);
        end
        default: begin
          r_acc <= r_acc;
          r_k   <= r_k;
        end
      endcase
    end
  end

endmodule

// File: doc/sbs_decoder.md
SBS_DECODER -- requirements
Module: sbs_decoder

Interface
REQ-001 Parameter BSL, default 255, is the stochastic bitstream length in bits.
REQ-002 Parameter CHUNK, default 8, is the number of stream bits counted per clock; legal range 1..BSL.
REQ-003 Parameter OUT_W, default $clog2(BSL+1), is the result width; it holds the value BSL without overflow.
REQ-004 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, is the reset; it is synchronous and active-high.
REQ-006 Port sbs, input, BSL, is the parallel stochastic bitstream; bit i is stream position i.
REQ-007 Port in_valid, input, 1, means sbs holds a complete stream (driven from the generator's done flag).
REQ-008 Port in_ready, output, 1, means the block accepts a stream this cycle.
REQ-009 Port value, output, OUT_W, is the count of ones in the accepted stream (unipolar binary estimate).
REQ-010 Port out_valid, output, 1, means value is final.
REQ-011 Port out_ready, input, 1, means the consumer takes value this cycle.
REQ-012 Port busy, output, 1, is high in COUNT and DONE states.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.
REQ-014 In IDLE: in_ready=1, out_valid=0, busy=0; all other states: in_ready=0.
REQ-015 Accept edge: in IDLE with in_valid=1, the edge SHALL copy sbs into an internal shadow register, clear accumulator and chunk index, and go to COUNT.
REQ-016 After capture, changes on sbs SHALL NOT affect the result.
REQ-017 In COUNT, each edge SHALL add popcount of shadow bits [k*CHUNK .. k*CHUNK+CHUNK-1] to the accumulator and increment k.
REQ-018 Bit positions at or above BSL in the final chunk SHALL count as zero.
REQ-019 N = ceil(BSL/CHUNK); after the N-th COUNT edge the state SHALL be DONE and the accumulator SHALL hold the full popcount.
REQ-020 Latency: out_valid SHALL rise exactly N edges after the accept edge (N=32 for defaults).
REQ-021 In DONE: out_valid=1, value=final count, held stable while out_ready=0, for any duration.
REQ-022 In DONE with out_ready=1, the edge SHALL return to IDLE; out_valid falls on that edge.
REQ-023 There is no bypass: in_valid during COUNT or DONE SHALL be ignored (in_ready=0), and a new stream is accepted no earlier than the cycle after DONE exits.
REQ-024 in_valid and out_ready asserted together in DONE SHALL retire the result only; no capture on that edge.
REQ-025 value SHALL read 0 whenever out_valid=0.
REQ-026 The accumulator SHALL be OUT_W bits; sum never exceeds BSL, so no wrap.
REQ-027 out_ready outside DONE SHALL have no effect.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, busy=0, value=0, accumulator=0, k=0, regardless of state or other inputs.
REQ-029 Reset during COUNT or DONE SHALL discard the captured stream; no partial result is ever presented.
REQ-030 rst takes priority over in_valid on the same edge; no capture occurs.
REQ-031 The shadow register needs no reset; its contents are don't-care in IDLE.

Verification
REQ-032 Defaults, sbs all zeros, one in_valid pulse -> out_valid high 32 edges after accept, value=0.
REQ-033 sbs all ones -> value=255; sbs alternating with bit0=1 -> value=128; only bit 254 set -> value=1.
REQ-034 BSL=20, CHUNK=8, all ones -> N=3, value=20 (pad bits ignored).
REQ-035 out_ready held low 10 cycles in DONE, in_valid=1 throughout -> value stable, in_ready=0, single retire on first out_ready=1, IDLE next cycle.
REQ-036 rst=1 on 5th COUNT edge -> next cycle in_ready=1, out_valid=0, value=0; fresh all-ones stream then returns 255.
REQ-037 sbs changed every cycle during COUNT -> result equals popcount of the stream at the accept edge.
